// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed multiply (radix-2 Booth) / divide
// (restoring) unit beside the ALU, with busy/tag for stall and writeback.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ctrl_MULT, ctrl_DIV   one-cycle requests (MULT has priority)
//   data_operandA/B       32-bit two's complement operands
//   dest_tag_in/out       5-bit destination register tag
//   data_result           product low word or quotient
//   data_exception        overflow or divide-by-zero
//   data_resultRDY        one-cycle result-valid pulse
//   busy                  high while an operation is iterating
module multdiv_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  dest_tag_in,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [4:0]  dest_tag_out
);

    typedef enum logic [1:0] {
        IDLE,
        MULT,
        DIV,
        DONE
    } state_t;

    state_t      state;
    state_t      stateNext;
    logic [5:0]  count;
    logic        lastIter;
    logic        divZero;

    logic [31:0] mcand;
    logic [64:0] prod;
    logic [64:0] prodNext;
    logic [32:0] boothSum;

    logic [31:0] divisor;
    logic [63:0] remQuo;
    logic [63:0] remQuoShift;
    logic [63:0] remQuoNext;
    logic [32:0] trial;
    logic [31:0] quotient;
    logic        negQ;

    logic [31:0] absA;
    logic [31:0] absB;

    assign lastIter = (count == 6'd31);
    assign divZero  = (data_operandB == 32'd0);
    assign absA     = data_operandA[31] ? -data_operandA : data_operandA;
    assign absB     = data_operandB[31] ? -data_operandB : data_operandB;

    // The Booth sum is kept 33 bits wide so subtracting the most negative
    // multiplicand keeps its true sign; the shift then drops that extra bit.
    always_comb begin
        boothSum = {prod[64], prod[64:33]};
        case (prod[1:0])
            2'b01:   boothSum = {prod[64], prod[64:33]} + {mcand[31], mcand};
            2'b10:   boothSum = {prod[64], prod[64:33]} - {mcand[31], mcand};
            default: boothSum = {prod[64], prod[64:33]};
        endcase
        prodNext = {boothSum, prod[32:1]};
    end

    // Restoring divide step on unsigned magnitudes.
    always_comb begin
        remQuoShift = {remQuo[62:0], 1'b0};
        trial       = {1'b0, remQuoShift[63:32]} - {1'b0, divisor};
        if (trial[32]) begin
            remQuoNext = remQuoShift;
        end else begin
            remQuoNext = {trial[31:0], remQuoShift[31:1], 1'b1};
        end
        quotient = remQuoNext[31:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext      = state;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        if (ctrl_MULT) begin
            stateNext = MULT;
        end else if (ctrl_DIV) begin
            stateNext = divZero ? DONE : DIV;
        end else begin
            case (state)
                MULT:    stateNext = lastIter ? DONE : MULT;
                DIV:     stateNext = lastIter ? DONE : DIV;
                DONE:    stateNext = IDLE;
                default: stateNext = IDLE;
            endcase
        end
        case (state)
            MULT:    busy = 1'b1;
            DIV:     busy = 1'b1;
            DONE:    data_resultRDY = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= 6'd0;
            mcand          <= 32'd0;
            prod           <= 65'd0;
            divisor        <= 32'd0;
            remQuo         <= 64'd0;
            negQ           <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            dest_tag_out   <= 5'd0;
        end else if (ctrl_MULT) begin
            count          <= 6'd0;
            mcand          <= data_operandA;
            prod           <= {32'd0, data_operandB, 1'b0};
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            dest_tag_out   <= dest_tag_in;
        end else if (ctrl_DIV) begin
            count          <= 6'd0;
            divisor        <= absB;
            remQuo         <= {32'd0, absA};
            negQ           <= data_operandA[31] ^ data_operandB[31];
            data_result    <= 32'd0;
            data_exception <= divZero;
            dest_tag_out   <= dest_tag_in;
        end else if (state == MULT) begin
            prod  <= prodNext;
            count <= lastIter ? 6'd0 : count + 6'd1;
            if (lastIter) begin
                data_result    <= prodNext[32:1];
                data_exception <= (prodNext[64:33] != {32{prodNext[32]}});
            end
        end else if (state == DIV) begin
            remQuo <= remQuoNext;
            count  <= lastIter ? 6'd0 : count + 6'd1;
            if (lastIter) begin
                data_result    <= negQ ? -quotient : quotient;
                // A positive quotient of 2^31 only arises from MIN / -1.
                data_exception <= ~negQ & quotient[31];
            end
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: random and directed checks of multdiv_sequencer
// against an arithmetic reference model.
module tb_multdiv_sequencer;

    logic        clock;
    logic        reset;
    logic        ctrlMult;
    logic        ctrlDiv;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  tagIn;
    logic [31:0] dataResult;
    logic        dataExc;
    logic        resultRdy;
    logic        busy;
    logic [4:0]  tagOut;

    int nChecks = 0;
    int nFails  = 0;

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrlMult),
        .ctrl_DIV       (ctrlDiv),
        .data_operandA  (opA),
        .data_operandB  (opB),
        .dest_tag_in    (tagIn),
        .data_result    (dataResult),
        .data_exception (dataExc),
        .data_resultRDY (resultRdy),
        .busy           (busy),
        .dest_tag_out   (tagOut)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkEq(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void refModel(input bit isMult,
                                     input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] r,
                                     output logic e);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (isMult) begin
            p = sa * sb;
            r = p[31:0];
            e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else begin
            p = sa / sb;
            r = p[31:0];
            e = (p > 64'sd2147483647);
        end
    endfunction

    task automatic runOp(input bit doMult, input bit doDiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag);
        logic [31:0] eRes;
        logic        eExc;
        int          lat;
        int          busyCnt;
        int          eLat;
        refModel(doMult, a, b, eRes, eExc);
        eLat = (!doMult && b == 32'd0) ? 1 : 33;
        ctrlMult = doMult;
        ctrlDiv  = doDiv;
        opA      = a;
        opB      = b;
        tagIn    = tag;
        @(negedge clock);
        ctrlMult = 1'b0;
        ctrlDiv  = 1'b0;
        opA      = $urandom;
        opB      = $urandom;
        tagIn    = 5'($urandom);
        lat      = 1;
        busyCnt  = 0;
        while (!resultRdy && lat < 40) begin
            busyCnt += int'(busy);
            @(negedge clock);
            lat++;
        end
        checkEq("latency", 64'(lat), 64'(eLat));
        checkEq("result", 64'(dataResult), 64'(eRes));
        checkEq("exception", 64'(dataExc), 64'(eExc));
        checkEq("tag", 64'(tagOut), 64'(tag));
        checkEq("busyCycles", 64'(busyCnt), 64'(eLat - 1));
        checkEq("busyAtRdy", 64'(busy), 64'd0);
        @(negedge clock);
        checkEq("rdyPulse", 64'(resultRdy), 64'd0);
        checkEq("hold", 64'(dataResult), 64'(eRes));
    endtask

    function automatic logic [31:0] randOperand();
        logic [15:0] h;
        h = 16'($urandom);
        case ($urandom_range(0, 3))
            0:       return {{16{h[15]}}, h};
            1:       return {28'd0, h[3:0]};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int          rdyCnt;
        int          firstLat;
        logic [31:0] r;
        logic [4:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        bit          m;

        reset    = 1'b1;
        ctrlMult = 1'b0;
        ctrlDiv  = 1'b0;
        opA      = 32'd0;
        opB      = 32'd0;
        tagIn    = 5'd0;
        repeat (2) @(negedge clock);
        checkEq("rstResult", 64'(dataResult), 64'd0);
        checkEq("rstExc", 64'(dataExc), 64'd0);
        checkEq("rstRdy", 64'(resultRdy), 64'd0);
        checkEq("rstBusy", 64'(busy), 64'd0);
        checkEq("rstTag", 64'(tagOut), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        runOp(1, 0, 32'h0000_0007, 32'hFFFF_FFFA, 5'd1);
        runOp(1, 0, 32'h0001_0000, 32'h0001_0000, 5'd2);
        runOp(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
        runOp(0, 1, 32'hFFFF_FF9C, 32'h0000_0007, 5'd4);
        runOp(0, 1, 32'h0000_0064, 32'hFFFF_FFF9, 5'd5);
        runOp(0, 1, 32'h1234_5678, 32'h0000_0000, 5'd6);
        runOp(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7);
        runOp(1, 0, 32'h8000_0000, 32'h8000_0000, 5'd8);
        runOp(0, 1, 32'h8000_0000, 32'h0000_0001, 5'd9);

        for (int i = 0; i < 40; i++) begin
            m = bit'($urandom_range(0, 1));
            a = randOperand();
            b = randOperand();
            if (!m && $urandom_range(0, 5) == 0) b = 32'd0;
            runOp(m, !m, a, b, 5'($urandom));
        end

        runOp(1, 1, 32'd3, 32'd4, 5'd12);

        ctrlMult = 1'b1;
        opA      = 32'd5;
        opB      = 32'd9;
        tagIn    = 5'd3;
        @(negedge clock);
        ctrlMult = 1'b0;
        repeat (9) @(negedge clock);
        ctrlDiv = 1'b1;
        opA     = 32'd20;
        opB     = 32'd3;
        tagIn   = 5'd17;
        @(negedge clock);
        ctrlDiv  = 1'b0;
        rdyCnt   = 0;
        firstLat = 0;
        r        = 32'd0;
        t        = 5'd0;
        for (int i = 1; i <= 45; i++) begin
            if (resultRdy) begin
                rdyCnt++;
                if (rdyCnt == 1) begin
                    firstLat = i;
                    r        = dataResult;
                    t        = tagOut;
                end
            end
            @(negedge clock);
        end
        checkEq("restartRdyCount", 64'(rdyCnt), 64'd1);
        checkEq("restartLatency", 64'(firstLat), 64'd33);
        checkEq("restartResult", 64'(r), 64'd6);
        checkEq("restartTag", 64'(t), 64'd17);

        ctrlMult = 1'b1;
        opA      = 32'd1234;
        opB      = 32'd5678;
        tagIn    = 5'd9;
        @(negedge clock);
        ctrlMult = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkEq("midRstResult", 64'(dataResult), 64'd0);
        checkEq("midRstExc", 64'(dataExc), 64'd0);
        checkEq("midRstRdy", 64'(resultRdy), 64'd0);
        checkEq("midRstBusy", 64'(busy), 64'd0);
        checkEq("midRstTag", 64'(tagOut), 64'd0);
        reset  = 1'b0;
        rdyCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            rdyCnt += int'(resultRdy);
        end
        checkEq("midRstNoRdy", 64'(rdyCnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
# multdiv_sequencer

Multi-cycle signed multiply/divide unit with its own control FSM, placed beside the ALU in the execute stage. It latches operands on a one-cycle request, runs a 32-iteration radix-2 Booth multiply or a 32-iteration restoring divide, and flags signed overflow and divide-by-zero. It returns the result with a one-cycle ready pulse, and drives `busy` and a destination tag so pipeline control can stall and write back.

## Interface
- No parameters. Widths are fixed at 32-bit operands and a 5-bit register tag.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `ctrl_MULT` in 1: one-cycle multiply request.
- `ctrl_DIV` in 1: one-cycle divide request.
- `data_operandA` in 32: multiplicand or dividend, two's complement.
- `data_operandB` in 32: multiplier or divisor, two's complement.
- `dest_tag_in` in 5: destination register, latched with the request.
- `data_result` out 32: product low word or quotient.
- `data_exception` out 1: overflow or divide-by-zero.
- `data_resultRDY` out 1: one-cycle pulse when the result is valid.
- `busy` out 1: high from the cycle after a request until `data_resultRDY` is high.
- `dest_tag_out` out 5: latched tag; valid while `busy` or `data_resultRDY` is high.

## Operation
- States: IDLE, MULT, DIV, DONE. A 6-bit iteration counter counts 0..31.
- Start:
  - In any state, a request sampled high loads the operands and tag, clears the counter, and enters MULT or DIV.
  - A request during MULT, DIV or DONE aborts the current operation and restarts. No result is produced for the aborted operation.
  - If both requests are high in the same cycle, `ctrl_MULT` wins.
- MULT:
  - Product register is 65 bits: {upper 32, lower 32 = B, Booth bit q-1 = 0}.
  - Each iteration inspects {P[1], q-1}: 01 adds A to the upper 32 bits, 10 subtracts A, 00 and 11 do nothing.
  - Each iteration then arithmetic-shifts the whole register right by 1.
  - After iteration 31 the state goes to DONE.
- MULT result and exception:
  - `data_result` = P[31:0] of the 64-bit product.
  - `data_exception` = 1 iff P[63:32] is not equal to 32 copies of P[31] (the product does not fit in 32 signed bits).
- DIV:
  - Latch the magnitudes |A| and |B| and the quotient sign = A[31] xor B[31].
  - Restoring algorithm on a 64-bit {remainder, quotient} register: shift left by 1, trial-subtract |B| from the remainder, keep the result and set the quotient LSB to 1 if the remainder is non-negative, otherwise restore.
  - 32 iterations, then DONE.
- DIV result:
  - Quotient truncates toward zero and is negated if the sign is set.
  - `data_exception` = 0, except in the two cases below.
- Divide-by-zero: if B = 0 at the request, go straight to DONE with `data_result` = 0 and `data_exception` = 1.
- Divide overflow: 0x80000000 / 0xFFFFFFFF gives `data_result` = 0x80000000 and `data_exception` = 1.
- DONE: `data_resultRDY` = 1 for exactly one cycle, then IDLE.
- Output hold: `data_result` and `data_exception` hold their values until the next request is accepted. They are cleared to 0 at that acceptance.

## Timing
- Reset:
  - Takes effect on the rising edge while `reset` = 1 and overrides any request in the same cycle.
  - State goes to IDLE and the counter to 0.
  - `data_result` = 0, `data_exception` = 0, `data_resultRDY` = 0, `busy` = 0, `dest_tag_out` = 0.
- Reset mid-operation: the operation is aborted, and no `data_resultRDY` follows.
- Edge numbering: the request is sampled at edge E0. Iterations run on edges E1..E32. The transition to DONE happens at E32.
- `data_resultRDY` is high in the cycle between E32 and E33, i.e. 32 cycles after the request edge.
- Divide-by-zero: `data_resultRDY` is high in the cycle right after E0 (latency 1).
- `busy` is high from after E0 through the cycle before DONE. It is low during DONE, so the stall releases on the same edge that writeback captures.
- Requests are pulses. A level held high restarts the operation every cycle and is a user error; it is not guarded.

## Test plan
- Multiply 7 × -6 (0x00000007, 0xFFFFFFFA) → after 32 cycles `data_resultRDY` pulses once with `data_result` = 0xFFFFFFD6 and `data_exception` = 0. `busy` is high for exactly 32 cycles.
- Multiply overflow: 0x00010000 × 0x00010000 → `data_result` = 0x00000000, `data_exception` = 1. Also 0x80000000 × 0xFFFFFFFF → `data_result` = 0x80000000, `data_exception` = 1.
- Divide -100 / 7 (0xFFFFFF9C, 0x00000007) → `data_result` = 0xFFFFFFF2 (-14), `data_exception` = 0. Also 100 / -7 → 0xFFFFFFF2.
- Divide by zero: 0x12345678 / 0 → `data_resultRDY` in the cycle after the request, `data_result` = 0, `data_exception` = 1. Also 0x80000000 / 0xFFFFFFFF → `data_result` = 0x80000000, `data_exception` = 1.
- Restart and priority:
  - `ctrl_DIV` at cycle 10 of a multiply, with operands 20 / 3, → exactly one `data_resultRDY`, 32 cycles later, with `data_result` = 6 and `dest_tag_out` = the second tag.
  - Both requests high together with 3 and 4 → `data_result` = 12.
- Reset mid-multiply at cycle 15 → all outputs are 0 on the next cycle, and no `data_resultRDY` is seen for 40 cycles.
